// File: rtl/pinmux_seq_pkg.sv
// Shared state encoding, error code and counter sizing for the pad pinmux
// reconfiguration sequencer.
package pinmux_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_QUIESCE = 3'd1;
  localparam state_t ST_APPLY   = 3'd2;
  localparam state_t ST_SETTLE  = 3'd3;
  localparam state_t ST_ENABLE  = 3'd4;
  localparam state_t ST_ACK     = 3'd5;

  localparam logic ERR_INVALID_SEL = 1'b1;

  // One counter serves both wait windows, so it is sized for the longer one.
  function automatic int cnt_width(input int quiesce_cyc, input int settle_cyc);
    int longest;
    longest = (quiesce_cyc > settle_cyc) ? quiesce_cyc : settle_cyc;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pinmux_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and the first
// asserted request wins; emits a one-hot grant plus its index.
module pinmux_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  always_comb begin
    logic [ID_W:0] slot;
    logic          found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    slot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One spare bit so ptr + i cannot wrap before the modulo correction.
      slot = {1'b0, ptr} + (ID_W+1)'(i);
      if (slot >= (ID_W+1)'(NUM_REQ)) slot = slot - (ID_W+1)'(NUM_REQ);
      if (!found && req[slot[ID_W-1:0]]) begin
        found               = 1'b1;
        gnt[slot[ID_W-1:0]] = 1'b1;
        gnt_id              = slot[ID_W-1:0];
      end
    end
    gnt_valid = found;
  end

endmodule

// File: rtl/pinmux_reconfig_seq.sv
// Break-before-make pad pinmux reconfiguration: quiesce the pad OE, switch the
// mux, settle, then restore OE; arbitrates between NUM_REQ requesters.
//
// state   | meaning
// IDLE    | arbitrate, latch winner, pick fast / error / full path
// QUIESCE | OE held low before the mux switch
// APPLY   | load sel/od/ie from shadow
// SETTLE  | OE held low after the mux switch
// ENABLE  | store and drive the new OE
// ACK     | pulse ack (and err) to the granted requester
module pinmux_reconfig_seq
  import pinmux_seq_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int NUM_PERIPHERALS = 4,
  parameter int SEL_WIDTH       = 5,
  parameter int QUIESCE_CYC     = 2,
  parameter int SETTLE_CYC      = 3,
  localparam int GID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]   i_req_sel,
  input  logic [NUM_REQ-1:0]             i_req_od,
  input  logic [NUM_REQ-1:0]             i_req_ie,
  input  logic [NUM_REQ-1:0]             i_req_oen,
  input  logic                           i_portstop,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_err,
  output logic                           o_busy,
  output logic [GID_W-1:0]               o_grant_id,
  output logic [SEL_WIDTH-1:0]           o_outfunc_sel,
  output logic                           o_pinctlx_od,
  output logic                           o_pinctlx_ie,
  output logic                           o_gpioquten
);

  localparam int CNT_W = cnt_width(QUIESCE_CYC, SETTLE_CYC);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [GID_W-1:0]     ptr;
  logic [SEL_WIDTH-1:0] sh_sel;
  logic                 sh_od;
  logic                 sh_ie;
  logic                 sh_oen;
  logic                 err_flag;
  logic                 oe_stored;
  logic                 oe_next;

  logic [NUM_REQ-1:0]   gnt;
  logic [GID_W-1:0]     gnt_id;
  logic                 gnt_valid;
  logic [SEL_WIDTH-1:0] win_sel;
  logic                 win_od;
  logic                 win_ie;
  logic                 win_oen;
  logic                 win_invalid;
  logic                 win_same;

  pinmux_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (GID_W)
  ) u_arb (
    .req       (i_req),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    win_sel = '0;
    win_od  = 1'b0;
    win_ie  = 1'b0;
    win_oen = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win_sel = i_req_sel[k*SEL_WIDTH +: SEL_WIDTH];
        win_od  = i_req_od[k];
        win_ie  = i_req_ie[k];
        win_oen = i_req_oen[k];
      end
    end
  end

  assign win_invalid = int'(win_sel) >= NUM_PERIPHERALS;
  // Compared against the stored OE, not the pin, so a port stop does not
  // force a needless full sequence.
  assign win_same    = (win_sel == o_outfunc_sel) && (win_od == o_pinctlx_od) &&
                       (win_ie == o_pinctlx_ie) && (win_oen == oe_stored);

  always_comb begin
    oe_next = oe_stored;
    case (state)
      ST_IDLE:    if (gnt_valid && !win_invalid && !win_same) oe_next = 1'b0;
      ST_QUIESCE,
      ST_APPLY,
      ST_SETTLE:  oe_next = 1'b0;
      ST_ENABLE:  oe_next = sh_oen;
      default:    oe_next = oe_stored;
    endcase
    if (i_portstop) oe_next = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptr           <= '0;
      sh_sel        <= '0;
      sh_od         <= 1'b0;
      sh_ie         <= 1'b0;
      sh_oen        <= 1'b0;
      err_flag      <= 1'b0;
      oe_stored     <= 1'b0;
      o_grant_id    <= '0;
      o_outfunc_sel <= '0;
      o_pinctlx_od  <= 1'b0;
      o_pinctlx_ie  <= 1'b0;
      o_gpioquten   <= 1'b0;
    end else begin
      o_gpioquten <= oe_next;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            sh_sel     <= win_sel;
            sh_od      <= win_od;
            sh_ie      <= win_ie;
            sh_oen     <= win_oen;
            o_grant_id <= gnt_id;
            err_flag   <= 1'b0;
            if (win_invalid) begin
              err_flag <= ERR_INVALID_SEL;
              state    <= ST_ACK;
            end else if (win_same) begin
              state <= ST_ACK;
            end else if (QUIESCE_CYC == 0) begin
              state <= ST_APPLY;
            end else begin
              state <= ST_QUIESCE;
              cnt   <= CNT_W'(QUIESCE_CYC - 1);
            end
          end
        end
        ST_QUIESCE: begin
          if (cnt == '0) state <= ST_APPLY;
          else           cnt   <= cnt - 1'b1;
        end
        ST_APPLY: begin
          o_outfunc_sel <= sh_sel;
          o_pinctlx_od  <= sh_od;
          o_pinctlx_ie  <= sh_ie;
          if (SETTLE_CYC == 0) begin
            state <= ST_ENABLE;
          end else begin
            state <= ST_SETTLE;
            cnt   <= CNT_W'(SETTLE_CYC - 1);
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_ENABLE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_ENABLE: begin
          oe_stored <= sh_oen;
          state     <= ST_ACK;
        end
        ST_ACK: begin
          ptr   <= (o_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + GID_W'(1);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ack = '0;
    if (state == ST_ACK) o_ack[o_grant_id] = 1'b1;
  end

  assign o_err  = (state == ST_ACK) && err_flag;
  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pinmux_reconfig_seq.sv
// Directed and randomized bench for pinmux_reconfig_seq, checked against a
// transaction-level model of pad state, arbitration order and latency.
module tb_pinmux_reconfig_seq;

  localparam int NUM_REQ         = 3;
  localparam int NUM_PERIPHERALS = 4;
  localparam int SEL_WIDTH       = 5;
  localparam int QUIESCE_CYC     = 2;
  localparam int SETTLE_CYC      = 3;
  localparam int FULL_LAT        = QUIESCE_CYC + SETTLE_CYC + 3;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req;
  logic [SEL_WIDTH-1:0]         r_sel [NUM_REQ];
  logic [NUM_REQ*SEL_WIDTH-1:0] req_sel;
  logic [NUM_REQ-1:0]           r_od;
  logic [NUM_REQ-1:0]           r_ie;
  logic [NUM_REQ-1:0]           r_oen;
  logic                         portstop;
  logic [NUM_REQ-1:0]           ack;
  logic                         err;
  logic                         busy;
  logic [1:0]                   grant_id;
  logic [SEL_WIDTH-1:0]         outfunc_sel;
  logic                         pin_od;
  logic                         pin_ie;
  logic                         gpioquten;

  // Reference model of the pad and arbiter.
  logic [SEL_WIDTH-1:0] m_sel;
  logic                 m_od;
  logic                 m_ie;
  logic                 m_oe;
  int                   m_ptr;
  int                   m_gid;
  logic                 ps_last;
  int                   checks = 0;
  int                   errors = 0;

  assign req_sel = {r_sel[2], r_sel[1], r_sel[0]};

  always #5 clk = ~clk;

  pinmux_reconfig_seq #(
    .NUM_REQ         (NUM_REQ),
    .NUM_PERIPHERALS (NUM_PERIPHERALS),
    .SEL_WIDTH       (SEL_WIDTH),
    .QUIESCE_CYC     (QUIESCE_CYC),
    .SETTLE_CYC      (SETTLE_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_sel     (req_sel),
    .i_req_od      (r_od),
    .i_req_ie      (r_ie),
    .i_req_oen     (r_oen),
    .i_portstop    (portstop),
    .o_ack         (ack),
    .o_err         (err),
    .o_busy        (busy),
    .o_grant_id    (grant_id),
    .o_outfunc_sel (outfunc_sel),
    .o_pinctlx_od  (pin_od),
    .o_pinctlx_ie  (pin_ie),
    .o_gpioquten   (gpioquten)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    ps_last = portstop;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sel = '0; m_od = 1'b0; m_ie = 1'b0; m_oe = 1'b0; m_ptr = 0; m_gid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ack"},  32'(ack), 0);
    chk({tag, ".err"},  32'(err), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".gid"},  32'(grant_id), 0);
    chk({tag, ".sel"},  32'(outfunc_sel), 0);
    chk({tag, ".od"},   32'(pin_od), 0);
    chk({tag, ".ie"},   32'(pin_ie), 0);
    chk({tag, ".oe"},   32'(gpioquten), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ack"},  32'(ack), 0);
    chk({tag, ".err"},  32'(err), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".gid"},  32'(grant_id), 32'(m_gid));
    chk({tag, ".sel"},  32'(outfunc_sel), 32'(m_sel));
    chk({tag, ".od"},   32'(pin_od), 32'(m_od));
    chk({tag, ".ie"},   32'(pin_ie), 32'(m_ie));
    chk({tag, ".oe"},   32'(gpioquten), ps_last ? 32'(0) : 32'(m_oe));
  endtask

  task automatic scramble();
    for (int i = 0; i < NUM_REQ; i++) r_sel[i] = SEL_WIDTH'($urandom_range(0, 31));
    r_od  = NUM_REQ'($urandom);
    r_ie  = NUM_REQ'($urandom);
    r_oen = NUM_REQ'($urandom);
  endtask

  // Called in an IDLE cycle. req_mode: 0 release at ack, 1 drop right after
  // grant (and scramble request data), 2 keep requests held.
  // ps_mode: 0 untouched, 1 random, 2 raise from the first settle cycle on.
  task automatic run_txn(input string tag, input logic [NUM_REQ-1:0] mask,
                         input int req_mode, input int ps_mode);
    int                   w;
    int                   lat;
    logic                 inv;
    logic                 full;
    logic [SEL_WIDTH-1:0] n_sel;
    logic                 n_od, n_ie, n_oen, base_oe;
    logic [NUM_REQ-1:0]   ack_exp;
    check_idle({tag, ".idle"});
    req = mask;
    w = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mask[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
    end
    n_sel = r_sel[w]; n_od = r_od[w]; n_ie = r_ie[w]; n_oen = r_oen[w];
    inv  = int'(n_sel) >= NUM_PERIPHERALS;
    full = !inv && !(n_sel == m_sel && n_od == m_od && n_ie == m_ie && n_oen == m_oe);
    lat  = full ? FULL_LAT : 1;
    ack_exp = NUM_REQ'(1) << w;
    if (ps_mode == 1) portstop = ($urandom_range(0, 5) == 0);
    for (int k = 1; k <= lat; k++) begin
      step();
      chk({tag, ".ack"},  32'(ack), (k == lat) ? 32'(ack_exp) : 32'(0));
      chk({tag, ".err"},  32'(err), 32'(k == lat && inv));
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".gid"},  32'(grant_id), 32'(w));
      if (full && k >= QUIESCE_CYC + 2) begin
        chk({tag, ".sel"}, 32'(outfunc_sel), 32'(n_sel));
        chk({tag, ".od"},  32'(pin_od), 32'(n_od));
        chk({tag, ".ie"},  32'(pin_ie), 32'(n_ie));
      end else begin
        chk({tag, ".sel"}, 32'(outfunc_sel), 32'(m_sel));
        chk({tag, ".od"},  32'(pin_od), 32'(m_od));
        chk({tag, ".ie"},  32'(pin_ie), 32'(m_ie));
      end
      base_oe = full ? ((k == lat) ? n_oen : 1'b0) : m_oe;
      chk({tag, ".oe"}, 32'(gpioquten), ps_last ? 32'(0) : 32'(base_oe));
      if (k == 1 && req_mode == 1) begin
        req = '0;
        scramble();
      end
      if (ps_mode == 1) portstop = ($urandom_range(0, 5) == 0);
      if (ps_mode == 2 && k == QUIESCE_CYC + 2) portstop = 1'b1;
    end
    m_gid = w;
    m_ptr = (w + 1) % NUM_REQ;
    if (full) begin
      m_sel = n_sel; m_od = n_od; m_ie = n_ie; m_oe = n_oen;
    end
    if (req_mode != 2) req = '0;
    step();
  endtask

  initial begin
    rst = 1'b1; req = '0; portstop = 1'b0; ps_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r_sel[i] = '0;
    r_od = '0; r_ie = '0; r_oen = '0;
    model_reset();
    step(); step(); step();
    check_all_zero("reset");
    rst = 1'b0;

    // Full sequence for requester 0, then the identical request (fast path).
    r_sel[0] = 5'd2; r_od[0] = 1'b0; r_ie[0] = 1'b1; r_oen[0] = 1'b1;
    run_txn("first", 3'b001, 0, 0);
    run_txn("same", 3'b001, 0, 0);

    // Invalid sel: immediate ack with err, pad untouched.
    r_sel[1] = 5'd7; r_od[1] = 1'b1; r_ie[1] = 1'b0; r_oen[1] = 1'b0;
    run_txn("badsel", 3'b010, 0, 0);

    // Requester 2 brings the pointer back to 0, with request dropped mid-way.
    r_sel[2] = 5'd3; r_od[2] = 1'b1; r_ie[2] = 1'b1; r_oen[2] = 1'b1;
    run_txn("drop", 3'b100, 1, 0);

    // All three held: grants rotate 0, 1, 2, 0.
    r_sel[0] = 5'd1; r_sel[1] = 5'd3; r_sel[2] = 5'd0;
    r_od = 3'b010; r_ie = 3'b101; r_oen = 3'b111;
    run_txn("rr0", 3'b111, 2, 0);
    run_txn("rr1", 3'b111, 2, 0);
    run_txn("rr2", 3'b111, 2, 0);
    run_txn("rr3", 3'b111, 0, 0);

    // Port stop raised during settle, released after ack.
    r_sel[1] = 5'd2; r_od[1] = 1'b1; r_ie[1] = 1'b0; r_oen[1] = 1'b1;
    run_txn("pstop", 3'b010, 0, 2);
    chk("pstop.held_oe", 32'(gpioquten), 0);
    portstop = 1'b0;
    step();
    chk("pstop.release_oe", 32'(gpioquten), 1);
    check_idle("pstop.after");

    // Reset in the middle of settle, then a normal request.
    r_sel[0] = 5'd3; r_od[0] = 1'b0; r_ie[0] = 1'b1; r_oen[0] = 1'b1;
    req = 3'b001;
    for (int k = 1; k <= QUIESCE_CYC + 3; k++) begin
      step();
      req = '0;
    end
    chk("midrst.busy_before", 32'(busy), 1);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    model_reset();
    run_txn("postrst", 3'b001, 0, 0);

    // Randomized traffic with occasional port stop and copies of the pad state.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r_sel[i] = m_sel; r_od[i] = m_od; r_ie[i] = m_ie; r_oen[i] = m_oe;
        end else begin
          r_sel[i] = SEL_WIDTH'($urandom_range(0, 5));
          r_od[i]  = 1'($urandom);
          r_ie[i]  = 1'($urandom);
          r_oen[i] = 1'($urandom);
        end
      end
      run_txn("rand", NUM_REQ'($urandom_range(1, 7)), int'($urandom_range(0, 1)), 1);
    end
    portstop = 1'b0;
    step();
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pinmux_reconfig_seq.md
Name: pinmux_reconfig_seq

Overview:
- Sequences safe, break-before-make reconfiguration of one pad's pinmux output function (outfunc_sel, OD, IE, output-enable).
- Arbitrates between NUM_REQ configuration requesters, for example the boot ROM config, the GPIO controller and the debug/port-stop agent.
- Drives the pad mux controls directly. The pad is quiesced (output-enable low) before the mux select changes, and stays quiesced for a settle window afterwards.
- Sits between the config register bus and the pad pinmux cell.

Parameters:
- NUM_REQ, 3, number of requesters (≥1).
- NUM_PERIPHERALS, 4, number of valid outfunc_sel values; sel ≥ NUM_PERIPHERALS is invalid.
- SEL_WIDTH, 5, width of outfunc_sel.
- QUIESCE_CYC, 2, cycles the pad OE is held low before the mux switch (0 allowed).
- SETTLE_CYC, 3, cycles after the mux switch before OE is re-enabled (0 allowed).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester request; held until the matching o_ack.
- i_req_sel  in  NUM_REQ*SEL_WIDTH  requested outfunc_sel; requester k uses slice [k*SEL_WIDTH +: SEL_WIDTH].
- i_req_od  in  NUM_REQ  requested open-drain enable.
- i_req_ie  in  NUM_REQ  requested input enable.
- i_req_oen  in  NUM_REQ  requested final output-enable (gpioquten).
- i_portstop  in  1  forces pad output-enable low while high.
- o_ack  out  NUM_REQ  1-cycle completion pulse to the granted requester.
- o_err  out  1  1-cycle pulse with o_ack when the requested sel was invalid.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current or last granted requester.
- o_outfunc_sel  out  SEL_WIDTH  registered mux select to the pad.
- o_pinctlx_od  out  1  registered OD control.
- o_pinctlx_ie  out  1  registered IE control.
- o_gpioquten  out  1  registered pad output-enable.

Behaviour:

Reset and outputs
- Every output resets to 0. The internal round-robin pointer, the stored OE value and the counters also reset to 0.
- Reset is synchronous and overrides everything: asserting it mid-sequence returns the FSM to IDLE and leaves the pad quiesced with sel 0.
- o_pinctlx_ie and o_pinctlx_od change only in APPLY.

FSM states: IDLE, QUIESCE, APPLY, SETTLE, ENABLE, ACK.

IDLE
- Round-robin arbitration over i_req. Requesters are searched starting at the pointer; the first asserted one wins.
- The winner's sel/od/ie/oen are latched into shadow registers and o_grant_id is updated.
- Fast path: if the latched sel/od/ie/oen equal the current outputs → go to ACK. The pad is not disturbed.
- Invalid sel (≥ NUM_PERIPHERALS) → go to ACK with o_err; the outputs are unchanged.
- Otherwise → QUIESCE. o_gpioquten goes to 0 on the next edge.

QUIESCE
- Holds for QUIESCE_CYC cycles, counted with a down-counter; then → APPLY.
- If QUIESCE_CYC=0, IDLE goes directly to APPLY. o_gpioquten is still cleared on that edge.

APPLY (1 cycle)
- Loads o_outfunc_sel, o_pinctlx_od and o_pinctlx_ie from the shadow registers.
- → SETTLE, or → ENABLE if SETTLE_CYC=0.

SETTLE
- Holds for SETTLE_CYC cycles; then → ENABLE.

ENABLE (1 cycle)
- Stores the shadow oen and loads o_gpioquten from it, gated by ~i_portstop.
- → ACK.

ACK (1 cycle)
- o_ack[grant]=1, plus o_err if flagged.
- The RR pointer moves to grant+1, wrapping at NUM_REQ.
- → IDLE. A new grant is possible on the next cycle.

Latency
- Take t as the IDLE cycle in which the request is sampled.
- o_gpioquten=0 from t+1.
- o_outfunc_sel is new from t+QUIESCE_CYC+2.
- o_ack and o_gpioquten (=oen) at t+QUIESCE_CYC+SETTLE_CYC+3.
- Fast path and invalid sel: o_ack at t+1.

Request handling
- A request deasserted mid-sequence is ignored; the sequence completes and the config is applied.
- Shadow registers are not updated after the grant, so request data may change without effect.
- A requester that keeps i_req high after its o_ack is re-arbitrated normally, at lowest priority.

Port stop
- While i_portstop=1, o_gpioquten is registered to 0 every cycle, in any state. The FSM keeps running.
- One cycle after i_portstop falls, o_gpioquten returns to the stored OE value, or stays 0 while in QUIESCE/APPLY/SETTLE.

Simultaneous requests
- Strictly round-robin; no requester is starved for more than NUM_REQ-1 grants.

Decomposition:
- Package pinmux_seq_pkg: the FSM state enum, a localparam for the counter width ($clog2(max(QUIESCE_CYC,SETTLE_CYC)+1)), and the invalid-sel error code.
- One sub-module: pinmux_rr_arbiter (NUM_REQ, combinational one-hot grant from req + pointer, plus an index encoder).

Test Plan:
- Reset, then req[0] with sel=2, od=0, ie=1, oen=1 (QUIESCE_CYC=2, SETTLE_CYC=3) → o_gpioquten=0 at t+1, o_outfunc_sel=2 at t+4, o_ack[0] and o_gpioquten=1 at t+8, o_busy low at t+9.
- Repeat the identical request → o_ack[0] at t+1 with no o_gpioquten dip.
- req[1] with sel=7 → o_ack[1] and o_err at t+1; o_outfunc_sel stays 2.
- req=3'b111 held continuously → grants in order 0, 1, 2, 0 and o_ack pulses rotate; the pointer wraps.
- i_portstop=1 during SETTLE and released after ACK → o_gpioquten=0 throughout, then 1 one cycle after release.
- i_rst asserted in SETTLE → next cycle all outputs 0, FSM in IDLE; a following request completes normally.
